mod_reg16_1to16: RTL and testbench
==================================

MOD_REG16_1TO16 -- requirements
Module: mod_reg16_1to16

Interface
REQ-001 SHALL have parameter N, default 16, number of bytes per block.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous and active-high (1 = reset).
REQ-004 SHALL have port i  input  8  serial byte from S-box ROM.
REQ-005 SHALL have port wr_en  input  1  byte on i valid this cycle.
REQ-006 SHALL have port rd_en  input  1  consumer takes the full 16-byte block this cycle.
REQ-007 SHALL have port o  output  N x 8 (packed [N-1:0][7:0])  assembled block, o[k] = k-th byte received.
REQ-008 SHALL have port reg_full  output  1  1 = all N bytes held, o valid.
REQ-009 SHALL have port count  output  5  bytes currently held, 0..16.

Function
REQ-010 SHALL implement a two-state FSM: FILL (collecting) and FULL (block held).
REQ-011 In FILL with wr_en=1, SHALL store i into o[count] and increment count; o[count] SHALL update at the next rising edge (1-cycle latency).
REQ-012 In FILL with wr_en=0, SHALL hold all state.
REQ-013 On the write that makes count reach 16, SHALL enter FULL, with reg_full=1 and count=16 from the next cycle.
REQ-014 In FILL, rd_en SHALL be ignored.
REQ-015 In FULL with wr_en=0, SHALL hold o unchanged.
REQ-016 In FULL with rd_en=1 and wr_en=0, SHALL return to FILL with count=0 and reg_full=0 next cycle; o SHALL keep its old contents until overwritten.
REQ-017 In FULL with rd_en=1 and wr_en=1 in the same cycle, SHALL return to FILL, store i into o[0], and set count=1 next cycle (no-bubble back-to-back blocks).
REQ-018 In FULL with wr_en=1 and rd_en=0, SHALL drop the byte and leave o, count and reg_full unchanged.
REQ-019 count SHALL never exceed 16; the byte index SHALL wrap from 15 to 0 only through the FULL->FILL transition.
REQ-020 o SHALL be driven directly from storage registers (no combinational path from i to o).

Reset
REQ-021 With resetn=1 at a rising edge, SHALL set state=FILL, count=0, reg_full=0, all o bytes=8'h00, and the overflow flag (if present) to 0.
REQ-022 Reset SHALL take priority over wr_en/rd_en in the same cycle, including mid-block and while FULL; partial blocks SHALL be discarded.

Configuration
REQ-023 When macro MOD_REG16_1TO16_OVF_FLAG_EN is defined, SHALL add output port ovf (1 bit), set sticky to 1 the cycle after any REQ-018 drop event, and clear it only by reset.
REQ-024 When MOD_REG16_1TO16_OVF_FLAG_EN is undefined, port ovf SHALL not exist, and drops SHALL be silent; all other behaviour SHALL be identical.

Verification
REQ-025 SHALL test full fill: reset, then write bytes 8'h00..8'h0F on 16 consecutive cycles -> reg_full=1 and count=16 one cycle after the last write, with o[k]=k for k=0..15.
REQ-026 SHALL test gapped fill: write 16 bytes 8'hA0..8'hAF with wr_en toggling 1/0 -> same final o as a gapless fill; reg_full=0 until the 16th write lands.
REQ-027 SHALL test back-to-back blocks: FULL, then rd_en=1 with wr_en=1 and i=8'h5A in the same cycle -> next cycle reg_full=0, count=1, o[0]=8'h5A, and o[1..15] unchanged.
REQ-028 SHALL test overflow: FULL, then wr_en=1 and i=8'hFF with rd_en=0 for 3 cycles -> o, count=16 and reg_full=1 unchanged; ovf=1 (macro defined) and stays 1 after a later rd_en.
REQ-029 SHALL test mid-block reset: after 7 writes, assert resetn for 1 cycle -> count=0, all o=0, reg_full=0; 16 new writes are then required before reg_full=1.
REQ-030 SHALL test spurious read: rd_en=1 in FILL with count=5 -> count stays 5 and o is unchanged.

Source files
------------

// File: rtl/mod_reg16_1to16.sv
// Serial-to-parallel block register: collects N bytes into one packed block.
// Optional sticky overflow flag enabled by defining MOD_REG16_1TO16_OVF_FLAG_EN.
module mod_reg16_1to16 #(
  parameter int N = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        i,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [N-1:0][7:0] o,
  output logic              reg_full,
  output logic [4:0]        count
`ifdef MOD_REG16_1TO16_OVF_FLAG_EN
  ,
  output logic              ovf
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [4:0]        count_q, count_d;
  logic [N-1:0][7:0] o_q, o_d;
  logic              drop;

  // Byte index restarts at 0 only when a held block is released.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    o_d     = o_q;
    drop    = 1'b0;
    case (state_q)
      FILL: begin
        if (wr_en) begin
          o_d[count_q[IW-1:0]] = i;
          count_d              = count_q + 5'd1;
          if (count_q == 5'(N - 1)) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (rd_en) begin
          state_d = FILL;
          if (wr_en) begin
            o_d[0]  = i;
            count_d = 5'd1;
          end else begin
            count_d = 5'd0;
          end
        end else if (wr_en) begin
          drop = 1'b1;
        end
      end
      default: begin
        state_d = FILL;
        count_d = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= FILL;
      count_q <= 5'd0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      o_q     <= o_d;
    end
  end

`ifdef MOD_REG16_1TO16_OVF_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (resetn) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  logic unusedDrop;
  assign unusedDrop = drop;
`endif

  assign o        = o_q;
  assign count    = count_q;
  assign reg_full = (state_q == FULL);

endmodule

// File: tb/tb_mod_reg16_1to16.sv
// Self-checking bench for mod_reg16_1to16 using a reference model and a scoreboard queue.
module tb_mod_reg16_1to16;

  logic              clk;
  logic              resetn;
  logic [7:0]        i;
  logic              wr_en;
  logic              rd_en;
  logic [15:0][7:0]  o;
  logic              reg_full;
  logic [4:0]        count;
`ifdef MOD_REG16_1TO16_OVF_FLAG_EN
  logic              ovf;
`endif

  mod_reg16_1to16 #(.N(16)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .i        (i),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .o        (o),
    .reg_full (reg_full),
    .count    (count)
`ifdef MOD_REG16_1TO16_OVF_FLAG_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0][7:0] o;
    logic [4:0]       cnt;
    logic             full;
  } exp_t;

  exp_t             sbq[$];
  exp_t             e;
  logic [15:0][7:0] m_o;
  logic [4:0]       m_cnt;
  logic             m_full;
  int               checks;
  int               passes;

  // Drive one cycle, advance the reference model, push its expectation.
  task automatic drive(input logic w, input logic r, input logic [7:0] d, input logic rst);
    wr_en  = w;
    rd_en  = r;
    i      = d;
    resetn = rst;
    if (rst) begin
      m_o = '0; m_cnt = 5'd0; m_full = 1'b0;
    end else if (!m_full) begin
      if (w) begin
        m_o[m_cnt[3:0]] = d;
        m_cnt = m_cnt + 5'd1;
        if (m_cnt == 5'd16) m_full = 1'b1;
      end
    end else if (r) begin
      m_full = 1'b0;
      if (w) begin
        m_o[0] = d;
        m_cnt  = 5'd1;
      end else begin
        m_cnt = 5'd0;
      end
    end
    sbq.push_back('{m_o, m_cnt, m_full});
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    resetn = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 8'h33, 1'b1);
    e = sbq.pop_front();
    checks++;
    if (o !== e.o || count !== e.cnt || reg_full !== e.full)
      $display("FAIL reset_sb: o=%h count=%0d full=%b, expected o=%h count=%0d full=%b", o, count, reg_full, e.o, e.cnt, e.full);
    else passes++;
    checks++;
    if (o !== '0 || count !== 5'd0 || reg_full !== 1'b0)
      $display("FAIL reset_state: o=%h count=%0d full=%b, expected all zero", o, count, reg_full);
    else passes++;
`ifdef MOD_REG16_1TO16_OVF_FLAG_EN
    checks++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf);
    else passes++;
`endif
  endtask

  task automatic test_full_fill();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b0, 8'(k), 1'b0);
      e = sbq.pop_front();
      checks++;
      if (o !== e.o || count !== e.cnt || reg_full !== e.full)
        $display("FAIL full_fill_sb[%0d]: o=%h count=%0d full=%b, expected o=%h count=%0d full=%b", k, o, count, reg_full, e.o, e.cnt, e.full);
      else passes++;
    end
    checks++;
    if (reg_full !== 1'b1 || count !== 5'd16)
      $display("FAIL full_fill_done: full=%b count=%0d, expected full=1 count=16", reg_full, count);
    else passes++;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (o[k] !== 8'(k)) $display("FAIL full_fill_byte[%0d]: got %h expected %h", k, o[k], 8'(k));
      else passes++;
    end
  endtask

  task automatic test_gapped_fill();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    void'(sbq.pop_front());
    for (int k = 0; k < 32; k++) begin
      drive(k % 2 == 0, 1'b0, 8'hA0 + 8'(k / 2), 1'b0);
      e = sbq.pop_front();
      checks++;
      if (o !== e.o || count !== e.cnt || reg_full !== e.full)
        $display("FAIL gapped_sb[%0d]: o=%h count=%0d full=%b, expected o=%h count=%0d full=%b", k, o, count, reg_full, e.o, e.cnt, e.full);
      else passes++;
      if (k < 30) begin
        checks++;
        if (reg_full !== 1'b0) $display("FAIL gapped_early_full[%0d]: got %b expected 0", k, reg_full);
        else passes++;
      end
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (o[k] !== 8'hA0 + 8'(k)) $display("FAIL gapped_byte[%0d]: got %h expected %h", k, o[k], 8'hA0 + 8'(k));
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 8'h5A, 1'b0);
    e = sbq.pop_front();
    checks++;
    if (o !== e.o || count !== e.cnt || reg_full !== e.full)
      $display("FAIL b2b_sb: o=%h count=%0d full=%b, expected o=%h count=%0d full=%b", o, count, reg_full, e.o, e.cnt, e.full);
    else passes++;
    checks++;
    if (reg_full !== 1'b0 || count !== 5'd1 || o[0] !== 8'h5A)
      $display("FAIL b2b_head: full=%b count=%0d o0=%h, expected full=0 count=1 o0=5a", reg_full, count, o[0]);
    else passes++;
    for (int k = 1; k < 16; k++) begin
      checks++;
      if (o[k] !== 8'hA0 + 8'(k)) $display("FAIL b2b_keep[%0d]: got %h expected %h", k, o[k], 8'hA0 + 8'(k));
      else passes++;
    end
  endtask

  task automatic test_spurious_read();
    logic [15:0][7:0] snap;
    for (int k = 1; k < 5; k++) begin
      drive(1'b1, 1'b0, 8'h10 + 8'(k), 1'b0);
      void'(sbq.pop_front());
    end
    snap = o;
    drive(1'b0, 1'b1, 8'hEE, 1'b0);
    e = sbq.pop_front();
    checks++;
    if (o !== e.o || count !== e.cnt || reg_full !== e.full)
      $display("FAIL spurious_sb: o=%h count=%0d full=%b, expected o=%h count=%0d full=%b", o, count, reg_full, e.o, e.cnt, e.full);
    else passes++;
    checks++;
    if (count !== 5'd5 || o !== snap || reg_full !== 1'b0)
      $display("FAIL spurious_read: count=%0d full=%b o=%h, expected count=5 full=0 o=%h", count, reg_full, o, snap);
    else passes++;
  endtask

  task automatic test_overflow();
    logic [15:0][7:0] snap;
    for (int k = 5; k < 16; k++) begin
      drive(1'b1, 1'b0, 8'h20 + 8'(k), 1'b0);
      void'(sbq.pop_front());
    end
    snap = o;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 8'hFF, 1'b0);
      e = sbq.pop_front();
      checks++;
      if (o !== snap || count !== 5'd16 || reg_full !== 1'b1 || o !== e.o)
        $display("FAIL overflow_hold[%0d]: o=%h count=%0d full=%b, expected o=%h count=16 full=1", k, o, count, reg_full, snap);
      else passes++;
    end
`ifdef MOD_REG16_1TO16_OVF_FLAG_EN
    checks++;
    if (ovf !== 1'b1) $display("FAIL overflow_flag: got %b expected 1", ovf);
    else passes++;
`endif
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    e = sbq.pop_front();
    checks++;
    if (count !== 5'd0 || reg_full !== 1'b0 || o !== snap || o !== e.o)
      $display("FAIL overflow_release: count=%0d full=%b o=%h, expected count=0 full=0 o=%h", count, reg_full, o, snap);
    else passes++;
`ifdef MOD_REG16_1TO16_OVF_FLAG_EN
    checks++;
    if (ovf !== 1'b1) $display("FAIL overflow_sticky: got %b expected 1", ovf);
    else passes++;
`endif
  endtask

  task automatic test_mid_block_reset();
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 1'b0, 8'h70 + 8'(k), 1'b0);
      void'(sbq.pop_front());
    end
    drive(1'b1, 1'b0, 8'h99, 1'b1);
    void'(sbq.pop_front());
    checks++;
    if (o !== '0 || count !== 5'd0 || reg_full !== 1'b0)
      $display("FAIL midreset_clear: o=%h count=%0d full=%b, expected all zero", o, count, reg_full);
    else passes++;
`ifdef MOD_REG16_1TO16_OVF_FLAG_EN
    checks++;
    if (ovf !== 1'b0) $display("FAIL midreset_ovf: got %b expected 0", ovf);
    else passes++;
`endif
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b0, 8'hC0 + 8'(k), 1'b0);
      e = sbq.pop_front();
      checks++;
      if (o !== e.o || count !== e.cnt || reg_full !== e.full || reg_full !== (k == 15))
        $display("FAIL midreset_refill[%0d]: o=%h count=%0d full=%b, expected o=%h count=%0d full=%b", k, o, count, reg_full, e.o, e.cnt, e.full);
      else passes++;
    end
    // Reset while FULL with both strobes active must still win.
    drive(1'b1, 1'b1, 8'h44, 1'b1);
    void'(sbq.pop_front());
    checks++;
    if (o !== '0 || count !== 5'd0 || reg_full !== 1'b0)
      $display("FAIL fullreset_clear: o=%h count=%0d full=%b, expected all zero", o, count, reg_full);
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    m_o    = '0;
    m_cnt  = 5'd0;
    m_full = 1'b0;
    resetn = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    i      = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_full_fill();
    test_gapped_fill();
    test_back_to_back();
    test_spurious_read();
    test_overflow();
    test_mid_block_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
